// File: rtl/fir_mac_scheduler_if.sv
// Sample, coefficient and result streams of the shared-multiplier FIR engine.
// master = stimulus/consumer side, slave = engine side.
interface fir_mac_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 18
);
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_data;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [1:0]               cfg_addr;
  logic signed [COEF_W-1:0] cfg_data;
  logic                     flush;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [ACC_W-1:0]  m_data;
  logic                     m_warm;
  logic                     busy;

  modport master (
    output s_valid, s_data, cfg_valid, cfg_addr, cfg_data, flush, m_ready,
    input  s_ready, cfg_ready, m_valid, m_data, m_warm, busy
  );

  modport slave (
    input  s_valid, s_data, cfg_valid, cfg_addr, cfg_data, flush, m_ready,
    output s_ready, cfg_ready, m_valid, m_data, m_warm, busy
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one signed MAC per tap, result valid TAPS+1 cycles after accept.
// Accepts samples/coefficients only in IDLE; result is held in OUT until m_ready.
module fir_mac_scheduler #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_mac_scheduler_if.slave bus
);
  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int PROD_W = DATA_W + COEF_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]               state;
  logic [DATA_W-1:0]        x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  m_data_q;
  logic                     m_warm_q;
  logic [TAP_W-1:0]         tap;
  logic [CNT_W-1:0]         warm_cnt;
  logic signed [DATA_W:0]   x_ext;
  logic signed [PROD_W-1:0] prod;
  logic                     in_idle;
  logic                     s_fire;
  logic                     cfg_fire;

  assign in_idle       = (state == ST_IDLE);
  assign bus.s_ready   = in_idle && !bus.cfg_valid && !bus.flush;
  assign bus.cfg_ready = in_idle && !bus.flush;
  assign s_fire        = bus.s_valid && bus.s_ready;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;

  // Samples are unsigned: a zero MSB keeps them positive in the signed product.
  assign x_ext   = $signed({1'b0, x[tap]});
  assign prod    = PROD_W'(x_ext) * PROD_W'(h[tap]);
  assign acc_nxt = acc + ACC_W'(prod);

  assign bus.m_valid = (state == ST_OUT);
  assign bus.m_data  = m_data_q;
  assign bus.m_warm  = m_warm_q;
  assign bus.busy    = !in_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      tap      <= '0;
      warm_cnt <= '0;
      m_data_q <= '0;
      m_warm_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= COEF_W'(1);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.flush) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            warm_cnt <= '0;
          end else if (cfg_fire) begin
            // Addresses beyond the tap count match no entry and are dropped.
            for (int i = 0; i < TAPS; i++) begin
              if (bus.cfg_addr == 2'(i)) h[i] <= bus.cfg_data;
            end
          end else if (s_fire) begin
            x[0] <= bus.s_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            tap <= '0;
            if (warm_cnt != CNT_W'(TAPS)) warm_cnt <= warm_cnt + 1'b1;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_nxt;
          tap <= tap + 1'b1;
          if (tap == TAP_W'(TAPS - 1)) begin
            m_data_q <= acc_nxt;
            m_warm_q <= (warm_cnt == CNT_W'(TAPS));
            state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.m_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
